// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
//   rx_state_t    : receiver FSM states (PARITY is always declared so the
//                   encoding is identical with or without parity support)
//   CLK_DIV_DEF   : default clocks per bit period
//   DATA_BITS_DEF : default data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned CLK_DIV_DEF   = 868;
  localparam int unsigned DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level. Both flops reset
// to 1 so an idle-high serial line looks idle straight out of reset.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_i, validates the start bit at half a bit
// period, samples data bits mid-bit (LSB first), checks the stop bit and
// offers the byte on a valid/ready handshake.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx_i         : serial line (idles high)
//   data_o       : received byte, held while valid_o && !ready_i
//   valid_o      : data_o holds an unconsumed byte
//   ready_i      : consumer accepts the byte (never stalls reception)
//   frame_err_o  : 1-clk pulse, stop bit sampled low
//   overrun_o    : 1-clk pulse, completed byte dropped (previous unread)
//   parity_err_o : 1-clk pulse with valid_o rising, even parity mismatch
//                  (only when UART_RX_PARITY_EN is defined)
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, then confirm start bit still low
// DATA   | sampling data bits once per bit period
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit, commit or flag framing error
// BREAK  | stop bit was low, wait for line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_good, stop_bad;
  logic                 can_load;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // Right shift: after DATA_BITS samples the first bit sits in the LSB.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_good = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The holding register is free if empty or being read this very cycle.
  assign can_load = !valid_o || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= stop_good && !can_load;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= stop_good && can_load && ((^shift_q) ^ par_q);
`endif
      if (stop_good && can_load) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLK_DIV=16, DATA_BITS=8). Stimulus pushes
// expected bytes/pulse counts; a negedge monitor pops and compares on every
// valid/ready transfer. Build with UART_RX_PARITY_EN to cover parity.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_DIV   = 16;
  localparam int unsigned DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Line change to stop-sample edge: 2 sync + 1 entry, half bit, then one
  // full bit per data/parity/stop bit.
  localparam int SAMPLE_LAT = 3 + CLK_DIV / 2 + CLK_DIV * (DATA_BITS + PAR + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
  int         n_perr = 0, exp_perr = 0;
`endif

  uart_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0;
  int n_valid_cyc = 0, n_ferr = 0, n_ovr = 0;
  int valid_rise_cyc = -1, ferr_cyc = -1, ovr_cyc = -1;
  int frame_t0 = 0;
  logic bp_mode = 1'b0, bp_full = 1'b0, rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor / scoreboard.
  logic [7:0] prev_data;
  logic prev_stall = 1'b0, prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (valid_o && !prev_valid) valid_rise_cyc = cyc;
      if (valid_o) n_valid_cyc++;
      if (frame_err_o) begin n_ferr++; ferr_cyc = cyc; end
      if (overrun_o) begin n_ovr++; ovr_cyc = cyc; end
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) begin
        n_perr++;
        check("perr_with_valid_rise", 32'(valid_o && !prev_valid), 32'(1));
      end
`endif
      if (prev_stall) check("data_hold", 32'(data_o), 32'(prev_data));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", data_o);
        end else begin
          check("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_valid = valid_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (CLK_DIV) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    frame_t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  // Reference model: a good frame is delivered unless the holding register
  // still contains an unread byte (only possible while ready is held low).
  task automatic deliver(input logic [7:0] b, input logic par_flip);
    if (bp_mode && bp_full) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(b);
      if (bp_mode) bp_full = 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_flip) exp_perr++;
`endif
    end
  endtask

  int v0, f0, o0, t1;
  logic [7:0] rb;
  logic bad;

  initial begin
    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;

    // Reset with a toggling line.
    for (int i = 0; i < 20; i++) begin
      rx_i = 1'($urandom_range(0, 1));
      step();
    end
    check("reset_outputs", 32'({data_o, valid_o, frame_err_o, overrun_o}), 32'(0));
    rx_i  = 1'b1;
    rst_n = 1'b1;
    idle(200);
    check("idle_no_valid", 32'(n_valid_cyc), 32'(0));
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Single frame.
    v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    deliver(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_valid_latency", 32'(valid_rise_cyc), 32'(frame_t0 + SAMPLE_LAT));
    check("a5_valid_len", 32'(n_valid_cyc - v0), 32'(1));
    check("a5_no_errs", 32'((n_ferr - f0) + (n_ovr - o0)), 32'(0));
    check("a5_drained", 32'(exp_q.size()), 32'(0));

    // Backpressure and overrun.
    o0 = n_ovr;
    ready_i = 1'b0; bp_mode = 1'b1; bp_full = 1'b0;
    deliver(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    deliver(8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(10);
    check("bp_data_kept", 32'(data_o), 32'(8'h3C));
    check("bp_valid_held", 32'(valid_o), 32'(1));
    check("bp_overrun_cnt", 32'(n_ovr - o0), 32'(1));
    check("bp_overrun_cyc", 32'(ovr_cyc), 32'(frame_t0 + SAMPLE_LAT));
    ready_i = 1'b1;
    idle(2);
    bp_mode = 1'b0; bp_full = 1'b0;
    check("bp_valid_cleared", 32'(valid_o), 32'(0));
    check("bp_drained", 32'(exp_q.size()), 32'(0));

    // Frame error followed by a stuck-low line.
    v0 = n_valid_cyc; f0 = n_ferr;
    exp_ferr++;
    send_frame(8'h55, 1'b0, 1'b0);
    t1 = frame_t0;
    idle(40);
    check("ferr_break_state", 32'(dut.state_q), 32'(BREAK));
    check("ferr_cnt", 32'(n_ferr - f0), 32'(1));
    check("ferr_cyc", 32'(ferr_cyc), 32'(t1 + SAMPLE_LAT));
    check("ferr_no_valid", 32'(n_valid_cyc - v0), 32'(0));
    rx_i = 1'b1;
    idle(5);
    check("ferr_back_idle", 32'(dut.state_q), 32'(IDLE));
    deliver(8'h01, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(20);
    check("ferr_next_drained", 32'(exp_q.size()), 32'(0));

    // False start glitch.
    v0 = n_valid_cyc; f0 = n_ferr;
    rx_i = 1'b0;
    idle(5);
    rx_i = 1'b1;
    idle(30);
    check("glitch_no_valid", 32'(n_valid_cyc - v0), 32'(0));
    check("glitch_no_ferr", 32'(n_ferr - f0), 32'(0));
    check("glitch_idle", 32'(dut.state_q), 32'(IDLE));

    // Reset during bit 4 of 0xFF.
    v0 = n_valid_cyc; f0 = n_ferr;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        idle(CLK_DIV * 5 + CLK_DIV / 2);
        rst_n = 1'b0;
        idle(1);
        check("midreset_outputs", 32'({data_o, valid_o, frame_err_o, overrun_o}), 32'(0));
        check("midreset_state", 32'(dut.state_q), 32'(IDLE));
        idle(2);
        rst_n = 1'b1;
      end
    join
    idle(20);
    check("midreset_no_valid", 32'(n_valid_cyc - v0), 32'(0));
    check("midreset_no_ferr", 32'(n_ferr - f0), 32'(0));
    deliver(8'h81, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check("midreset_one_byte", 32'(n_valid_cyc - v0), 32'(1));
    check("midreset_drained", 32'(exp_q.size()), 32'(0));
`ifdef UART_RX_PARITY_EN
    deliver(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(20);
    check("parity_err_cnt", 32'(n_perr), 32'(exp_perr));
`endif

    // Randomised frames with random consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if (bad) exp_ferr++;
      else deliver(rb, 1'b0);
      send_frame(rb, !bad, 1'b0);
      rx_i = 1'b1;
      idle(int'($urandom_range(3, 20)));
    end
    idle(30);
    rand_ready = 1'b0;
    ready_i = 1'b1;
    idle(5);
    check("final_drained", 32'(exp_q.size()), 32'(0));
    check("final_ferr_cnt", 32'(n_ferr), 32'(exp_ferr));
    check("final_ovr_cnt", 32'(n_ovr), 32'(exp_ovr));
`ifdef UART_RX_PARITY_EN
    check("final_perr_cnt", 32'(n_perr), 32'(exp_perr));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that sits directly upstream of the UART shift/read control stage. It synchronises the asynchronous `rx_i` line, detects and validates the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte on a valid/ready handshake. The frame format is 8N1 LSB-first; even parity is optional.

## Interface
- `CLK_DIV`, default 868: clocks per bit period; legal range 4 to 65535.
- `DATA_BITS`, default 8: data bits per frame; legal range 5 to 8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_i`  in  1  serial line; asynchronous to `clk`; idles high.
- `data_o`  out  DATA_BITS  received byte, LSB = first bit on the wire.
- `valid_o`  out  1  `data_o` holds an unconsumed byte.
- `ready_i`  in  1  consumer accepts the byte.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: a completed byte was dropped.

## Operation
- `rx_i` passes through a 2-flop synchroniser, giving `rx_s`. Reset value of `rx_s` is 1.
- A bit counter `cnt` (width clog2(CLK_DIV)) and a data index `idx` (width clog2(DATA_BITS)) are used.
- FSM states and transitions:
  - IDLE: if `rx_s`==0, go to START with `cnt`=0.
  - START: when `cnt`==CLK_DIV/2−1 (integer divide), sample `rx_s`.
    - If 1, it is a false start: go to IDLE.
    - If 0, go to DATA with `cnt`=0 and `idx`=0.
  - DATA: when `cnt`==CLK_DIV−1, shift `rx_s` into the MSB of the shift register (right shift), then `idx`++ and `cnt`=0. After bit DATA_BITS−1, go to STOP (or PARITY when that feature is compiled in).
  - STOP: when `cnt`==CLK_DIV−1, sample `rx_s`.
    - If 1, commit the byte and go to IDLE.
    - If 0, pulse `frame_err_o`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A stuck-low line therefore never retriggers a frame.
- Commit rule:
  - If `valid_o`==0, or `valid_o`&&`ready_i` in the same cycle, load `data_o` and set `valid_o`=1.
  - Otherwise keep the old `data_o`, drop the new byte, and pulse `overrun_o`.
- Handshake: a transfer occurs when `valid_o`&&`ready_i`. `valid_o` clears on the next cycle unless a commit coincides with it. `data_o` is stable while `valid_o`&&!`ready_i`.
- `ready_i` never affects reception; the line is sampled regardless of backpressure.

## Timing
- Reset values: state=IDLE, `data_o`=0, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `cnt`=0, `idx`=0, synchroniser flops=1.
- Falling edge on `rx_i` to the IDLE→START transition: 3 clk (2 synchroniser cycles + 1).
- Bit k (0-based) is sampled CLK_DIV/2 + (k+1)·CLK_DIV cycles after START entry.
- `valid_o` rises 1 clk after the stop-bit sample.
- `frame_err_o` and `overrun_o` assert in the cycle after the stop sample and last exactly 1 clk.
- Reset asserted mid-frame: all state clears immediately, with no commit and no error pulse. After release the FSM is in IDLE and re-arms on the next low `rx_s`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP and samples one even-parity bit at CLK_DIV−1.
  - An extra output `parity_err_o` (1 bit, reset 0) pulses for 1 clk, in the same cycle `valid_o` rises, when XOR(data bits, parity bit)==1.
  - The byte is still committed on a parity error; the consumer decides what to do with it.
- Not defined: no PARITY state and no `parity_err_o` port; the frame is 8N1.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP, BREAK}; PARITY is always declared.
  - `localparam` default CLK_DIV.
  - `localparam` default DATA_BITS.
- Sub-module `uart_sync2`: 2-flop synchroniser, with parameter-free 1-bit ports `clk`, `rst_n`, `d`, `q` and reset value 1.
- The counter and FSM stay in `uart_rx`.

## Test plan
All scenarios use CLK_DIV=16 and DATA_BITS=8.
- Reset: hold `rst_n`=0 with `rx_i` toggling → all outputs are 0; after release, an idle-high line produces no `valid_o` for 200 clk.
- Single frame: send 0xA5 with `ready_i`=1 → `valid_o` rises 1 clk after the stop sample, `data_o`=0xA5, `valid_o` lasts 1 clk, no error pulses.
- Backpressure and overrun: send 0x3C then 0xC3 with `ready_i`=0 → `data_o` stays 0x3C, `overrun_o` pulses once at the second stop sample; raising `ready_i` clears `valid_o`.
- Frame error: send 0x55 with the stop bit low, then hold low for 40 clk → `frame_err_o` pulses once, `valid_o` stays 0, FSM is in BREAK until high, and the next frame 0x01 is received correctly.
- False start: a 5-clk low glitch on `rx_i` → FSM returns to IDLE, no `valid_o`, no `frame_err_o`.
- Mid-frame reset: assert `rst_n` during bit 4 of 0xFF, release, then send 0x81 → only 0x81 is delivered. With `UART_RX_PARITY_EN`, send 0x81 with parity bit 1 → `parity_err_o` pulses with `valid_o`.
